irq_encoder: RTL
================

IRQ_ENCODER -- requirements
Module: irq_encoder

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the number of request lines; SIZE SHALL be a power of two, 2..32.
REQ-002 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port i_Req, input, SIZE bits: request lines, level-sampled each cycle; bit n high sets pending bit n.
REQ-005 The block SHALL have port i_Enable, input, SIZE bits: per-line enable mask applied at selection.
REQ-006 The block SHALL have port i_Disable, input, 1 bit: global inhibit of new presentations.
REQ-007 The block SHALL have port i_Ack, input, 1 bit: consumer accepts the presented index.
REQ-008 The block SHALL have port o_Valid, output, 1 bit: an index is presented.
REQ-009 The block SHALL have port o_Index, output, $clog2(SIZE) bits: the presented line number.
REQ-010 The block SHALL have port o_Pending, output, SIZE bits: the registered pending vector.

Function
REQ-011 Pending update, every cycle: pending_next = (pending & ~clr) | i_Req, where clr is one-hot of o_Index only in the CLEAR state; set SHALL win over clear on the same bit.
REQ-012 Candidate = pending & i_Enable; selection SHALL pick the lowest set bit index (bit 0 highest priority).
REQ-013 FSM states: IDLE, PRESENT, CLEAR.
REQ-014 IDLE -> PRESENT when candidate is nonzero and i_Disable is low; o_Index SHALL be registered with the selected index on that edge, and o_Valid SHALL be high for the whole of PRESENT.
REQ-015 In PRESENT, o_Index SHALL be held stable regardless of i_Req, i_Enable or i_Disable changes; the block SHALL never withdraw a presentation.
REQ-016 PRESENT -> CLEAR when i_Ack is high; PRESENT -> PRESENT otherwise.
REQ-017 CLEAR lasts exactly one cycle with o_Valid low, clears pending[o_Index] per REQ-011, then goes to IDLE.
REQ-018 i_Ack outside PRESENT SHALL be ignored.
REQ-019 Latency: i_Req bit high at edge k sets pending at edge k; o_Valid SHALL be high after edge k+1, given IDLE, enabled and not disabled.
REQ-020 Minimum spacing between two presentations SHALL be 3 cycles: PRESENT, CLEAR, IDLE.
REQ-021 Candidate zero, or i_Disable high, SHALL keep the FSM in IDLE with pending still accumulating.
REQ-022 Disabled lines SHALL stay pending and SHALL become eligible as soon as they are enabled.

Reset
REQ-023 While i_Rst_n is low: state = IDLE, pending = 0, o_Valid = 0, o_Index = 0, o_Pending = 0, asynchronously.
REQ-024 Reset asserted mid-PRESENT or mid-CLEAR SHALL drop the presentation with no pending bit retained.
REQ-025 The first state change SHALL occur on the first i_Clk edge after deassertion.

Structure
REQ-026 FSM state encoding (2-bit localparams IDLE=0, PRESENT=1, CLEAR=2) SHALL live in the shared package irq_pkg.
REQ-027 Lowest-set-bit selection SHALL be a combinational sub-module priority_encoder, parameterised by SIZE, with outputs index and any.
REQ-028 All outputs SHALL be registered or taken directly from registers.

Verification
REQ-029 Single request: i_Req=8'h04 for 1 cycle, i_Enable=8'hFF -> o_Valid=1, o_Index=2 after next edge; with i_Ack=1 for one cycle, o_Pending=0 two edges later.
REQ-030 Priority: i_Req=8'h90 -> o_Index=4; after ack and CLEAR -> o_Index=7; after ack -> idle, o_Pending=0.
REQ-031 Masking and disable: pending 8'h01 with i_Enable=8'h00 -> o_Valid stays 0 for 10 cycles; set i_Enable=8'h01 with i_Disable=1 -> still 0; drop i_Disable -> o_Valid=1, o_Index=0.
REQ-032 Collision: in CLEAR for index 3, i_Req=8'h08 the same cycle -> o_Pending[3] stays 1 and index 3 is re-presented.
REQ-033 Stability: in PRESENT with index 5, raise i_Req=8'h01 -> o_Index remains 5 until ack, then presents 0.
REQ-034 Reset mid-PRESENT with pending 8'hFF: i_Rst_n low asynchronously -> o_Valid=0, o_Pending=0 before the next clock edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt encoder: FSM encoding and helpers.
package irq_pkg;

  // Raw 2-bit state encodings.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] CLEAR   = 2'd2;

  // Typed view of the same encodings, used by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_PRESENT = PRESENT,
    ST_CLEAR   = CLEAR
  } irq_state_e;

  // Legal request-line counts: powers of two from 2 to 32.
  function automatic bit size_is_legal(input int size);
    return (size >= 2) && (size <= 32) && ((size & (size - 1)) == 0);
  endfunction

endpackage : irq_pkg

// File: rtl/irq_encoder_if.sv
// Groups the request/enable/ack bus of the interrupt encoder.
//
// Handshake: the encoder (slave) raises valid with a stable index and holds
// both until the consumer (master) raises ack for one cycle while valid is
// high; ack while valid is low has no effect. The encoder never withdraws a
// presentation once valid is high.
interface irq_encoder_if #(
  parameter int SIZE = 8
);
  localparam int IW = $clog2(SIZE);

  logic [SIZE-1:0] req;
  logic [SIZE-1:0] enable;
  logic            inhibit;
  logic            ack;
  logic            valid;
  logic [IW-1:0]   index;
  logic [SIZE-1:0] pending;
  logic [1:0]      dbg_state;

  // Consumer side: raises requests, masks lines, acknowledges.
  modport master (
    output req, enable, inhibit, ack,
    input  valid, index, pending, dbg_state
  );

  // Encoder side.
  modport slave (
    input  req, enable, inhibit, ack,
    output valid, index, pending, dbg_state
  );
endinterface : irq_encoder_if

// File: rtl/irq_encoder_priority_encoder.sv
// Combinational lowest-set-bit selector: bit 0 has the highest priority.
module priority_encoder #(
  parameter int SIZE = 8,
  localparam int IW  = $clog2(SIZE)
) (
  input  logic [SIZE-1:0] req,
  output logic [IW-1:0]   index,
  output logic            any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    any   = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = IW'(i);
        any   = 1'b1;
      end
    end
  end

endmodule : priority_encoder

// File: rtl/irq_encoder.sv
// Interrupt encoder: accumulates level requests into a pending vector,
// presents the lowest enabled pending line, and clears it after ack.
module irq_encoder
  import irq_pkg::*;
#(
  parameter int SIZE = 8,
  localparam int IW  = $clog2(SIZE)
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic [SIZE-1:0] i_Req,
  input  logic [SIZE-1:0] i_Enable,
  input  logic            i_Disable,
  input  logic            i_Ack,
  output logic            o_Valid,
  output logic [IW-1:0]   o_Index,
  output logic [SIZE-1:0] o_Pending,
  output logic [1:0]      o_Dbg_State
);

  irq_state_e      state_q, state_d;
  logic [SIZE-1:0] pending_q, pending_d;
  logic [IW-1:0]   index_q, index_d;
  logic            valid_q, valid_d;

  logic [SIZE-1:0] clr;
  logic [SIZE-1:0] candidate;
  logic [IW-1:0]   sel_index;
  logic            sel_any;

  // Selection works on the registered pending vector, so a request seen at
  // one edge is presentable from the following edge.
  assign candidate = pending_q & i_Enable;

  priority_encoder #(
    .SIZE (SIZE)
  ) u_prio (
    .req   (candidate),
    .index (sel_index),
    .any   (sel_any)
  );

  // Pending update: clear only the presented line during CLEAR; a new
  // request on the same bit wins over the clear.
  always_comb begin
    clr = '0;
    if (state_q == ST_CLEAR) begin
      clr[index_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | i_Req;
  end

  // Next-state and registered-output logic for the presentation FSM.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any && !i_Disable) begin
          state_d = ST_PRESENT;
          index_d = sel_index;
          valid_d = 1'b1;
        end
      end
      ST_PRESENT: begin
        // Index is frozen here; only ack moves us on.
        if (i_Ack) begin
          state_d = ST_CLEAR;
          valid_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
    end
  end

  assign o_Valid     = valid_q;
  assign o_Index     = index_q;
  assign o_Pending   = pending_q;
  assign o_Dbg_State = state_q;

endmodule : irq_encoder
